// File: rtl/kovacs_pkg.sv
// Shared phase encodings and indicator levels for the Kovacs feedback scheduler,
// also consumed by the datapath and the software register map.
package kovacs_pkg;

  localparam logic [1:0] PH_FREE = 2'd0;
  localparam logic [1:0] PH_RESC = 2'd1;
  localparam logic [1:0] PH_ZERO = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd3;

  localparam logic [13:0] IND_FREE = 14'd8191;
  localparam logic [13:0] IND_RESC = 14'd4096;
  localparam logic [13:0] IND_ZERO = 14'd0;

  typedef struct packed {
    logic [13:0] data;
    logic [13:0] ind;
  } out_t;

  // ZERO and IDLE both drive the quiet level on data and indicator.
  function automatic out_t phase_out(input logic [1:0] ph, input logic [13:0] d,
                                     input logic [13:0] dr);
    out_t o;
    case (ph)
      PH_FREE: o = '{data: d,  ind: IND_FREE};
      PH_RESC: o = '{data: dr, ind: IND_RESC};
      default: o = '{data: '0, ind: IND_ZERO};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/kovacs_scheduler_if.sv
// Control, sample and status bundle between the scheduler and its host.
interface kovacs_scheduler_if #(
  parameter int CNT_W = 32,
  parameter int REP_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] T_free_i;
  logic [CNT_W-1:0] T_zero_i;
  logic [CNT_W-1:0] T_resc_i;
  logic [REP_W-1:0] n_cycles_i;
  logic [15:0]      data_i;
  logic [15:0]      data_rescaled_i;
  logic [13:0]      data_o;
  logic [13:0]      indicator_o;
  logic [1:0]       phase_o;
  logic             busy_o;
  logic             done_o;
  logic [REP_W-1:0] cycle_count_o;

  modport master (
    output start_i, abort_i, T_free_i, T_zero_i, T_resc_i, n_cycles_i, data_i, data_rescaled_i,
    input  data_o, indicator_o, phase_o, busy_o, done_o, cycle_count_o
  );
  modport slave (
    input  start_i, abort_i, T_free_i, T_zero_i, T_resc_i, n_cycles_i, data_i, data_rescaled_i,
    output data_o, indicator_o, phase_o, busy_o, done_o, cycle_count_o
  );
endinterface

// File: rtl/kovacs_phase_timer.sv
// Phase duration counter: counts 0..T while enabled and flags the last cycle.
module kovacs_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] t_i,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q;

  // Cleared on every phase change, so it never counts past T (no overflow at all-ones).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign last_o = en_i && (cnt_q == t_i);
endmodule

// File: rtl/kovacs_scheduler.sv
// FREE -> ZERO -> RESCALED protocol sequencer with registered phase-selected output.
module kovacs_scheduler #(
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  kovacs_scheduler_if.slave bus
);
  import kovacs_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tf_q, tf_d, tz_q, tz_d, tr_q, tr_d, t_cur;
  logic [REP_W-1:0] n_q, n_d, cyc_q, cyc_d, cyc_inc;
  logic             done_q, done_d, last, relatch;
  out_t             out_q, out_d;
  logic             unused_lsbs;

  assign unused_lsbs = ^{bus.data_i[1:0], bus.data_rescaled_i[1:0]};

  always_comb begin
    case (state_q)
      PH_FREE: t_cur = tf_q;
      PH_ZERO: t_cur = tz_q;
      default: t_cur = tr_q;
    endcase
  end

  kovacs_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_d != state_q),
    .en_i   (state_q != PH_IDLE),
    .t_i    (t_cur),
    .last_o (last)
  );

  assign cyc_inc = cyc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    relatch = 1'b0;
    // Abort wins over start and over phase completion; count is frozen.
    if (bus.abort_i) state_d = PH_IDLE;
    else begin
      case (state_q)
        PH_IDLE: if (bus.start_i) begin
          state_d = PH_FREE;
          relatch = 1'b1;
          n_d     = bus.n_cycles_i;
          cyc_d   = '0;
        end
        PH_FREE: if (last) state_d = PH_ZERO;
        PH_ZERO: if (last) state_d = PH_RESC;
        default: if (last) begin
          cyc_d = cyc_inc;
          if (n_q != '0 && cyc_inc == n_q) begin
            state_d = PH_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PH_FREE;
            relatch = 1'b1;
          end
        end
      endcase
    end
    tf_d = relatch ? bus.T_free_i : tf_q;
    tz_d = relatch ? bus.T_zero_i : tz_q;
    tr_d = relatch ? bus.T_resc_i : tr_q;
  end

  assign out_d = phase_out(state_q, bus.data_i[15:2], bus.data_rescaled_i[15:2]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PH_IDLE;
      tf_q    <= '0;
      tz_q    <= '0;
      tr_q    <= '0;
      n_q     <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      tf_q    <= tf_d;
      tz_q    <= tz_d;
      tr_q    <= tr_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.phase_o       = state_q;
  assign bus.busy_o        = (state_q != PH_IDLE);
  assign bus.done_o        = done_q;
  assign bus.cycle_count_o = cyc_q;
  assign bus.data_o        = out_q.data;
  assign bus.indicator_o   = out_q.ind;
endmodule

// File: doc/kovacs_scheduler.md
KOVACS_SCHEDULER -- requirements
Module: kovacs_scheduler

Interface
REQ-001 Parameter CNT_W, default 32: width of the phase duration inputs and the phase counter.
REQ-002 Parameter REP_W, default 16: width of n_cycles_i and cycle_count_o.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  single-cycle pulse; begins a protocol run.
REQ-006 abort_i  in  1  level; terminates a run.
REQ-007 T_free_i  in  CNT_W  FREE phase length minus 1, in cycles.
REQ-008 T_zero_i  in  CNT_W  ZERO phase length minus 1, in cycles.
REQ-009 T_resc_i  in  CNT_W  RESCALED phase length minus 1, in cycles.
REQ-010 n_cycles_i  in  REP_W  number of full protocol cycles per run; 0 means run until abort.
REQ-011 data_i  in  16  raw feedback sample.
REQ-012 data_rescaled_i  in  16  rescaled feedback sample.
REQ-013 data_o  out  14  registered, phase-selected output.
REQ-014 indicator_o  out  14  registered phase marker.
REQ-015 phase_o  out  2  current phase: 0 FREE, 1 RESCALED, 2 ZERO, 3 IDLE.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 done_o  out  1  one-cycle pulse on normal run completion.
REQ-018 cycle_count_o  out  REP_W  number of completed protocol cycles in the current or last run.

Function
REQ-019 The FSM SHALL have four states, IDLE, FREE, ZERO and RESCALED, and SHALL cycle FREE -> ZERO -> RESCALED -> FREE.
REQ-020 IDLE + start_i=1 + abort_i=0 SHALL go to FREE next cycle; at that edge the block SHALL latch T_free_i, T_zero_i, T_resc_i and n_cycles_i, zero the phase counter and clear cycle_count_o.
REQ-021 Each phase SHALL last exactly T+1 cycles: the counter runs 0..T, and the phase advances in the cycle after the counter equals the latched T.
REQ-022 A T of 0 SHALL give a one-cycle phase; a T of all-ones SHALL be legal without counter overflow.
REQ-023 Duration inputs SHALL be re-latched only on the edge that enters FREE; changes mid-cycle take effect at the next cycle boundary.
REQ-024 On leaving RESCALED, cycle_count_o SHALL increment, wrapping modulo 2^REP_W.
REQ-025 If latched n_cycles ≠ 0 and the incremented count equals it, the next state SHALL be IDLE and done_o SHALL pulse in that same edge's following cycle; otherwise the next state SHALL be FREE.
REQ-026 abort_i=1 SHALL force IDLE on the next edge from any state, overriding start_i and phase completion, with no done_o pulse; cycle_count_o SHALL hold its value.
REQ-027 start_i while busy_o=1 SHALL be ignored.
REQ-028 data_o/indicator_o SHALL be registered from the current state, one cycle latency:
  FREE: data_i[15:2], 8191.
  RESCALED: data_rescaled_i[15:2], 4096.
  ZERO: 0, 0.
  IDLE: 0, 0.
REQ-029 phase_o and busy_o SHALL reflect the state register directly, with no extra delay.

Reset
REQ-030 While rst_ni=0, the block SHALL hold: state IDLE, counter 0, latched parameters 0, data_o 0, indicator_o 0, phase_o 3, busy_o 0, done_o 0, cycle_count_o 0.
REQ-031 Reset asserted mid-run SHALL abandon the run immediately, with no done_o pulse.
REQ-032 After release, the block SHALL ignore start_i only if it is sampled in the same cycle as the release edge.

Structure
REQ-033 Phase encodings (0..3) and indicator levels 8191/4096/0 SHALL live in the shared kovacs_pkg package, for reuse by the datapath and software register maps.
REQ-034 One sub-module, kovacs_phase_timer, SHALL be used: load, count 0..T, last-cycle flag.
REQ-035 The FSM and output mux SHALL stay in kovacs_scheduler.

Verification
REQ-036 Tf=2, Tz=1, Tr=3, n=2, start: phases SHALL be FREE 3 / ZERO 2 / RESCALED 4 cycles, twice, then IDLE; done_o SHALL pulse once; cycle_count_o SHALL end at 2.
REQ-037 All T=0, n=0: phase_o SHALL step 0,2,1,0,... every cycle; cycle_count_o SHALL wrap 0xFFFF -> 0; run until abort_i, after which IDLE follows on the next edge with no done_o.
REQ-038 data_i=0x8004, data_rescaled_i=0x4008: in FREE, data_o SHALL be 0x2001 and indicator_o 8191; in RESCALED, 0x1002 and 4096; in ZERO, 0 and 0; each one cycle after the phase change.
REQ-039 Change T_zero_i from 5 to 1 during the ZERO phase of cycle 1: the current ZERO SHALL still last 6 cycles; the cycle 2 ZERO SHALL last 2 cycles.
REQ-040 Assert start_i mid-run, and start_i together with abort_i in IDLE: the run SHALL be unaffected / the block SHALL stay IDLE.
REQ-041 Assert rst_ni=0 mid-RESCALED: all outputs SHALL reach REQ-030 values asynchronously, with no done_o pulse.
